mc_ctrl_fsm: RTL and testbench

Multi-cycle sequencer for the RV32I datapath. It steps each instruction through fetch, decode, execute, memory and writeback over several cycles. It drives the same control set as the single-cycle decoder (regwrite, memory strobes, ALU sources, aluop), plus PC/IR write enables and a shared-memory handshake. It sits between the shared instruction/data memory port and the register file/ALU, and replaces per-cycle combinational control.

---
 rtl/mc_ctrl_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: steps FETCH/DECODE/EXEC/MEM/WB over a shared memory port.
// Stalls in FETCH/MEM until mem_ready; halts on illegal opcode or memory timeout until reset.
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 regwrite,
  output logic [1:0]           wb_sel,
  output logic                 alusrc1,
  output logic                 alusrc2,
  output logic [2:0]           aluop,
  output logic                 illegal,
  output logic                 timeout,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] ALU_NOP    = 3'd0;
  localparam logic [2:0] ALU_R_TYPE = 3'd1;
  localparam logic [2:0] ALU_I_TYPE = 3'd2;
  localparam logic [2:0] ALU_LOAD   = 3'd3;
  localparam logic [2:0] ALU_STORE  = 3'd4;
  localparam logic [2:0] ALU_BRANCH = 3'd5;
  localparam logic [2:0] ALU_JUMP   = 3'd6;
  localparam logic [2:0] ALU_U_TYPE = 3'd7;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [2:0]    next_state;
  logic [6:0]    op_q;
  logic [TW-1:0] tcnt;
  logic          tmo_hit;
  logic          retire;
  logic          is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic [2:0]    alu_class;

  function automatic logic op_ok(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_ok = 1'b1;
      default:                           op_ok = 1'b0;
    endcase
  endfunction

  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BR);
  assign is_jal    = (op_q == OP_JAL);
  assign is_jalr   = (op_q == OP_JALR);
  assign is_lui    = (op_q == OP_LUI);
  assign is_auipc  = (op_q == OP_AUIPC);

  always_comb begin
    alu_class = ALU_NOP;
    case (op_q)
      OP_R:              alu_class = ALU_R_TYPE;
      OP_IMM:            alu_class = ALU_I_TYPE;
      OP_LOAD:           alu_class = ALU_LOAD;
      OP_STORE:          alu_class = ALU_STORE;
      OP_BR:             alu_class = ALU_BRANCH;
      OP_JAL, OP_JALR:   alu_class = ALU_JUMP;
      OP_LUI, OP_AUIPC:  alu_class = ALU_U_TYPE;
      default:           alu_class = ALU_NOP;
    endcase
  end

  // Counter reaches MEM_TIMEOUT-1 on the MEM_TIMEOUT-th unanswered request cycle.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (tcnt == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)    next_state = S_DECODE;
        else if (tmo_hit) next_state = S_HALT;
      end
      S_DECODE: next_state = op_ok(opcode) ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_load || is_store) next_state = S_MEM;
        else if (is_branch)      next_state = S_FETCH;
        else                     next_state = S_WB;
      end
      S_MEM: begin
        if (mem_ready)    next_state = is_load ? S_WB : S_FETCH;
        else if (tmo_hit) next_state = S_HALT;
      end
      S_WB:    next_state = S_FETCH;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_HALT;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = 2'b00;
    regwrite = 1'b0;
    wb_sel   = 2'b00;
    alusrc1  = 1'b0;
    alusrc2  = 1'b0;
    aluop    = ALU_NOP;
    retire   = 1'b0;
    if (!rst) begin
      if (state == S_EXEC || state == S_MEM || state == S_WB) begin
        aluop   = alu_class;
        alusrc1 = is_jal || is_auipc;
        alusrc2 = (op_q == OP_IMM) || is_load || is_store || is_lui || is_auipc || is_jalr;
      end
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        S_EXEC: begin
          if (is_branch) begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'b01 : 2'b00;
            retire   = 1'b1;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_store;
          if (is_store && mem_ready) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end
        end
        S_WB: begin
          regwrite = 1'b1;
          pc_write = 1'b1;
          retire   = 1'b1;
          if (is_load)               wb_sel = 2'b01;
          else if (is_jal || is_jalr) wb_sel = 2'b10;
          else if (is_lui)           wb_sel = 2'b11;
          if (is_jal)       pc_src = 2'b01;
          else if (is_jalr) pc_src = 2'b10;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      tcnt    <= '0;
      instret <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (state == S_DECODE) begin
        op_q <= opcode;
        if (!op_ok(opcode)) illegal <= 1'b1;
      end
      if ((state == S_FETCH || state == S_MEM) && !mem_ready && tmo_hit)
        timeout <= 1'b1;
      if (next_state != state || mem_ready)
        tcnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
        tcnt <= tcnt + 1'b1;
      if (retire)
        instret <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed-vector bench for mc_ctrl_fsm with hand-computed expectations.
module tb_mc_ctrl_fsm;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, regwrite;
  logic        alusrc1, alusrc2, illegal, timeout;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  aluop, state;
  logic [31:0] instret;

  int n_cmp = 0;
  int n_err = 0;

  mc_ctrl_fsm #(.MEM_TIMEOUT(16), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .regwrite(regwrite),
    .wb_sel(wb_sel), .alusrc1(alusrc1), .alusrc2(alusrc2), .aluop(aluop),
    .illegal(illegal), .timeout(timeout), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for the current cycle and let combinational outputs settle.
  task automatic drive(input logic rdy, input logic [6:0] op, input logic bt);
    mem_ready    = rdy;
    opcode       = op;
    branch_taken = bt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {mem_req, mem_we, ir_write, pc_write, regwrite};
  endfunction

  initial begin
    logic [4:0] acc;
    rst = 1'b1;
    drive(1'b0, 7'd0, 1'b0);
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_strobes", strobes(), 0);
    chk("rst_aluop", aluop, 0);
    chk("rst_instret", instret, 0);
    rst = 1'b0;

    // ADD, zero-wait
    drive(1'b1, ADD, 1'b0);
    chk("add_f_state", state, 0);
    chk("add_f_req_ir", {mem_req, iord, mem_we, ir_write}, 4'b1001);
    tick();
    chk("add_d_state", state, 1);
    chk("add_d_alu", {aluop, regwrite}, 0);
    tick();
    chk("add_e_state", state, 2);
    chk("add_e_alu", {aluop, regwrite, pc_write}, {3'd1, 2'b00});
    tick();
    chk("add_wb_state", state, 4);
    chk("add_wb_ctl", {regwrite, pc_write, wb_sel, pc_src, aluop}, {2'b11, 2'b00, 2'b00, 3'd1});
    chk("add_wb_instret", instret, 0);
    tick();
    chk("add_done_state", state, 0);
    chk("add_instret", instret, 1);

    // LW with MEM stalled 3 cycles
    drive(1'b1, LW, 1'b0); tick();
    drive(1'b1, LW, 1'b0); tick();
    drive(1'b0, LW, 1'b0);
    chk("lw_e_alu", {aluop, alusrc1, alusrc2}, {3'd3, 2'b01});
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, LW, 1'b0);
      chk("lw_mem_wait", {state, mem_req, iord, mem_we, ir_write}, {3'd3, 4'b1100});
      tick();
    end
    drive(1'b1, LW, 1'b0);
    chk("lw_mem_done", {state, mem_req, iord, mem_we, pc_write}, {3'd3, 4'b1100});
    tick();
    chk("lw_wb", {state, regwrite, wb_sel}, {3'd4, 1'b1, 2'b01});
    tick();
    chk("lw_instret", {state, instret[3:0]}, {3'd0, 4'd2});

    // BEQ taken, then BNE not taken
    for (int b = 0; b < 2; b++) begin
      drive(1'b1, BR, 1'b0); tick();
      drive(1'b1, BR, 1'b0);
      chk("br_d_pcw", {pc_write, regwrite}, 0);
      tick();
      drive(1'b0, BR, (b == 0));
      chk("br_e_ctl", {state, pc_write, pc_src, regwrite, aluop},
          {3'd2, 1'b1, (b == 0) ? 2'b01 : 2'b00, 1'b0, 3'd5});
      tick();
      chk("br_done", {state, instret[3:0], pc_write}, {3'd0, 4'(3 + b), 1'b0});
    end

    // JALR then LUI
    drive(1'b1, JALR, 1'b0); tick(); tick();
    chk("jalr_e", {pc_write, alusrc2, aluop}, {2'b01, 3'd6});
    tick();
    chk("jalr_wb", {state, wb_sel, pc_src, alusrc1, alusrc2, regwrite},
        {3'd4, 2'b10, 2'b10, 3'b011});
    tick();
    drive(1'b1, LUI, 1'b0); tick(); tick(); tick();
    chk("lui_wb", {state, wb_sel, pc_src, aluop, alusrc2}, {3'd4, 2'b11, 2'b00, 3'd7, 1'b1});
    tick();
    chk("lui_instret", instret, 6);

    // SW zero-wait: 4 cycles, retire from MEM
    drive(1'b1, SW, 1'b0); tick(); tick(); tick();
    chk("sw_mem", {state, mem_req, iord, mem_we, pc_write, pc_src, regwrite},
        {3'd3, 4'b1111, 2'b00, 1'b0});
    tick();
    chk("sw_done", {state, instret[3:0]}, {3'd0, 4'd7});

    // FETCH timeout: 16 unanswered cycles
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, ADD, 1'b0); tick();
    end
    chk("tmo_15", {state, timeout}, {3'd0, 1'b0});
    drive(1'b0, ADD, 1'b0); tick();
    chk("tmo_halt", {state, timeout}, {3'd5, 1'b1});
    drive(1'b1, ADD, 1'b0);
    chk("tmo_halt_strobes", strobes(), 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("tmo_rst", {state, timeout, instret[3:0]}, {3'd0, 1'b0, 4'd0});

    // mem_ready on the 16th FETCH cycle wins
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, ADD, 1'b0); tick();
    end
    drive(1'b1, ADD, 1'b0);
    chk("tmo_edge_ir", ir_write, 1);
    tick();
    chk("tmo_edge_dec", {state, timeout}, {3'd1, 1'b0});
    tick(); tick(); tick();
    chk("tmo_edge_retire", {state, instret[3:0]}, {3'd0, 4'd1});

    // Illegal opcode -> HALT for good
    drive(1'b1, BAD, 1'b0); tick();
    tick();
    chk("ill_halt", {state, illegal}, {3'd5, 1'b1});
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      drive(i[0], ADD, 1'b1);
      acc = acc | strobes();
      tick();
    end
    chk("ill_strobes", {acc, state, aluop}, {5'd0, 3'd5, 3'd0});
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ill_rst", {state, illegal, instret[3:0]}, {3'd0, 1'b0, 4'd0});

    // Reset mid-MEM drops mem_req combinationally
    drive(1'b1, LW, 1'b0); tick(); tick(); tick();
    drive(1'b0, LW, 1'b0);
    chk("mid_mem_req", {state, mem_req}, {3'd3, 1'b1});
    rst = 1'b1; #1;
    chk("mid_rst_req", strobes(), 0);
    tick(); rst = 1'b0; #1;
    chk("mid_rst_state", {state, mem_req}, {3'd0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
